// File: rtl/program_loader_pkg.sv
// Shared processor package: loader FSM state encoding and the default fill value
// returned for unloaded or blocked instruction reads.
package program_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } pl_state_e;

  localparam logic [7:0] PL_FILL_DEFAULT = 8'h00;

endpackage

// File: rtl/program_memory.sv
// Program storage: 2^ADDR_W x DATA_W, synchronous write, asynchronous read.
// Contents are deliberately not reset; the loader masks stale bytes.
module program_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Byte write on accepted transfer
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/program_loader.sv
// Program loader: streams a program into local memory while holding the CPU,
// then releases it and serves instruction fetches bounded by prog_length.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int                 ADDR_W = 8,
  parameter int                 DATA_W = 8,
  parameter logic [DATA_W-1:0]  FILL   = DATA_W'(PL_FILL_DEFAULT)
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_end,
  input  logic [ADDR_W-1:0] read_address,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   prog_length,
  output logic              load_done
);

  localparam logic [ADDR_W:0] LAST_LEN = {1'b0, {ADDR_W{1'b1}}};

  pl_state_e         state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              ready_q;
  logic              hold_q;
  logic              done_q;
  logic              mem_we_s;
  logic [DATA_W-1:0] rd_data_s;

  // Next-state, pointer/length update and write strobe
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    len_d    = len_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          len_d    = '0;
        end else begin
          state_d  = state_q;
        end
      end
      ST_LOAD: begin
        // A restart discards whatever transfer coincides with it
        if (load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          len_d    = '0;
        end else begin
          if (load_valid) begin
            mem_we_s = 1'b1;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            len_d    = len_q + (ADDR_W+1)'(1);
          end else begin
            mem_we_s = 1'b0;
          end
          if (load_end || (load_valid && (len_q == LAST_LEN))) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered handshake/status outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
      ready_q  <= 1'b0;
      hold_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
      ready_q  <= (state_d == ST_LOAD);
      hold_q   <= (state_d != ST_RUN);
      done_q   <= (state_d == ST_RUN) && (state_q != ST_RUN);
    end
  end

  program_memory #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clock     (clock),
    .wr_en_i   (mem_we_s),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (load_data),
    .rd_addr_i (read_address),
    .rd_data_o (rd_data_s)
  );

  // Fetch is only served in RUN and only below the loaded length
  always_comb begin
    if ((state_q == ST_RUN) && ({1'b0, read_address} < len_q)) begin
      instruction = rd_data_s;
    end else begin
      instruction = FILL;
    end
  end

  assign load_ready  = ready_q;
  assign cpu_hold    = hold_q;
  assign load_done   = done_q;
  assign prog_length = len_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: a mode/length/array reference model
// predicts each cycle's outputs; a negedge monitor pops and compares.
module tb_program_loader;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN  = 2;

  logic       clock = 1'b0;
  logic       clear = 1'b0;
  logic       load_start = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       load_end = 1'b0;
  logic [7:0] read_address = 8'h00;
  logic [7:0] instruction;
  logic       cpu_hold;
  logic [8:0] prog_length;
  logic       load_done;

  program_loader dut (
    .clock        (clock),
    .clear        (clear),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .load_end     (load_end),
    .read_address (read_address),
    .instruction  (instruction),
    .cpu_hold     (cpu_hold),
    .prog_length  (prog_length),
    .load_done    (load_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         hold;
    bit         ready;
    bit         done;
    int         len;
    logic [7:0] instr;
    logic [7:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model
  int         m_mode  = M_IDLE;
  int         m_len   = 0;
  bit         m_done  = 1'b0;
  bit         m_known = 1'b0;
  logic [7:0] m_mem [256];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  task automatic drive(input bit clr, input bit st, input bit v, input logic [7:0] d,
                       input bit e, input logic [7:0] ra);
    exp_t x;
    clear = clr; load_start = st; load_valid = v; load_data = d; load_end = e;
    read_address = ra;
    if (m_known) begin
      x.hold  = (m_mode != M_RUN);
      x.ready = (m_mode == M_LOAD);
      x.done  = m_done;
      x.len   = m_len;
      x.instr = (m_mode == M_RUN && int'(ra) < m_len) ? m_mem[ra] : 8'h00;
      x.addr  = ra;
      exp_q.push_back(x);
    end
    m_done = 1'b0;
    if (clr) begin
      m_mode = M_IDLE; m_len = 0; m_known = 1'b1;
    end else if (m_mode == M_LOAD) begin
      if (st) begin
        m_len = 0;
      end else begin
        if (v) begin
          m_mem[m_len] = d;
          m_len++;
        end
        if (e || m_len == 256) begin
          m_mode = M_RUN; m_done = 1'b1;
        end
      end
    end else if (st) begin
      m_mode = M_LOAD; m_len = 0;
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input logic [7:0] ra);
    drive(1'b0, 1'b0, 1'b0, 8'($urandom), 1'b0, ra);
  endtask

  // Monitor: compare each presented cycle against the oldest prediction
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cpu_hold", int'(cpu_hold), int'(e.hold));
        chk("load_ready", int'(load_ready), int'(e.ready));
        chk("load_done", int'(load_done), int'(e.done));
        chk("prog_length", int'(prog_length), e.len);
        if (instruction !== e.instr) begin
          checks++;
          errors++;
          $display("FAIL instruction addr=%0h at %0t: actual=%0h required=%0h",
                   e.addr, $time, instruction, e.instr);
        end else begin
          checks++;
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st, v, e, clr;
    logic [7:0] ra;
    // reset, then IDLE with ignored load_end/load_valid
    drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h00);
    idle(8'h01);

    // basic three-byte program
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h42, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    for (int a = 0; a < 5; a++) idle(8'(a));

    // run -> restart: hold rises, reads masked
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(8'h00);
    // last byte with load_end
    drive(1'b0, 1'b0, 1'b1, 8'h10, 1'b0, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'h7E, 1'b1, 8'h01);
    idle(8'h01); idle(8'h02); idle(8'h00);

    // restart coinciding with a transfer
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    idle(8'h00); idle(8'h01); idle(8'h02);

    // zero-length program
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00);
    idle(8'h00); idle(8'h00);

    // clear mid-load after five bytes
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 8'(8'hE0 + i), 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 8'hFE, 1'b1, 8'h00);
    idle(8'h00); idle(8'h03);

    // full 256-byte program, auto RUN
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 8'($urandom));
    drive(1'b0, 1'b0, 1'b1, 8'h99, 1'b0, 8'hFF);
    drive(1'b0, 1'b0, 1'b1, 8'h98, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) idle(8'($urandom));

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      clr = ($urandom_range(0, 99) == 0);
      st  = ($urandom_range(0, 29) == 0);
      v   = ($urandom_range(0, 9) < 6);
      e   = ($urandom_range(0, 19) == 0);
      ra  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      drive(clr, st, v, 8'($urandom), e, ra);
    end
    idle(8'h00); idle(8'h00);

    chk("queue_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
